dma_address: RTL and testbench

DMA engine between an 8-bit CPU port and a 4-bit memory port. The CPU hands it a 32-bit address and a byte length through an address handshake. The engine forwards that descriptor to memory, then moves exactly `len` bytes in the direction selected by `mode`. Bytes are split into or assembled from nibbles, low nibble first, and buffered in a 4-byte FIFO. It sits between the CPU model and the memory model, and all transfers use valid/enable handshakes.

---
 rtl/dma_address.sv | 185 ++++++++++++++++++
 tb/tb_dma_address.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_address.sv
// DMA engine between an 8-bit CPU port and a 4-bit memory port: accepts a descriptor,
// forwards it to memory, then moves len bytes through a byte FIFO split into nibbles.
module dma_address #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        mode,
    input  logic        address_in_valid,
    output logic        address_in_enable,
    input  logic [31:0] addr_in,
    input  logic [31:0] len_in,
    output logic        address_out_valid,
    input  logic        address_out_enable,
    output logic [31:0] address_reg,
    output logic [31:0] len_reg,
    input  logic        cpu_to_dma_valid,
    output logic        cpu_to_dma_enable,
    input  logic [7:0]  cpu_data_out,
    output logic        dma_to_cpu_valid,
    input  logic        dma_to_cpu_enable,
    output logic [7:0]  cpu_data_in,
    input  logic        mem_to_dma_valid,
    output logic        mem_to_dma_enable,
    input  logic [3:0]  mem_data_out,
    output logic        dma_to_mem_valid,
    input  logic        dma_to_mem_enable,
    output logic [3:0]  mem_data_in
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_e;

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] len_q, len_d;
    logic        mode_q, mode_d;
    logic [31:0] in_cnt_q, in_cnt_d;
    logic [31:0] out_cnt_q, out_cnt_d;
    logic        tx_hi_q, tx_hi_d;
    logic        rx_hi_q, rx_hi_d;
    logic [3:0]  stage_q, stage_d;
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic [7:0]  fifo_q [FIFO_DEPTH];

    logic        fifo_empty, fifo_full, src_ok;
    logic        in_idle, in_addr, in_data;
    logic        push, pop;
    logic [7:0]  push_data;
    logic [7:0]  head;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head       = fifo_q[rd_ptr_q[AW-1:0]];
    assign src_ok     = !fifo_full && (in_cnt_q < len_q);

    assign in_idle = (state_q == S_IDLE);
    assign in_addr = (state_q == S_ADDR);
    assign in_data = (state_q == S_DATA);

    // Handshake outputs depend only on registered state, forced low while in reset.
    assign address_in_enable = in_idle & resetn;
    assign address_out_valid = in_addr & resetn;
    assign cpu_to_dma_enable = in_data & mode_q & src_ok & resetn;
    assign dma_to_mem_valid  = in_data & mode_q & !fifo_empty & resetn;
    assign mem_to_dma_enable = in_data & !mode_q & src_ok & resetn;
    assign dma_to_cpu_valid  = in_data & !mode_q & !fifo_empty & resetn;

    assign address_reg = addr_q;
    assign len_reg     = len_q;
    assign cpu_data_in = head;
    assign mem_data_in = tx_hi_q ? head[7:4] : head[3:0];

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        len_d     = len_q;
        mode_d    = mode_q;
        in_cnt_d  = in_cnt_q;
        out_cnt_d = out_cnt_q;
        tx_hi_d   = tx_hi_q;
        rx_hi_d   = rx_hi_q;
        stage_d   = stage_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        push      = 1'b0;
        pop       = 1'b0;
        push_data = 8'h00;

        case (state_q)
            S_IDLE: begin
                if (address_in_valid && address_in_enable) begin
                    addr_d    = addr_in;
                    len_d     = len_in;
                    mode_d    = mode;
                    in_cnt_d  = 32'd0;
                    out_cnt_d = 32'd0;
                    tx_hi_d   = 1'b0;
                    rx_hi_d   = 1'b0;
                    stage_d   = 4'h0;
                    wr_ptr_d  = '0;
                    rd_ptr_d  = '0;
                    state_d   = S_ADDR;
                end
            end
            S_ADDR: begin
                if (address_out_valid && address_out_enable)
                    state_d = (len_q == 32'd0) ? S_IDLE : S_DATA;
            end
            S_DATA: begin
                if (mode_q) begin
                    if (cpu_to_dma_valid && cpu_to_dma_enable) begin
                        push      = 1'b1;
                        push_data = cpu_data_out;
                        in_cnt_d  = in_cnt_q + 32'd1;
                    end
                    if (dma_to_mem_valid && dma_to_mem_enable) begin
                        tx_hi_d = !tx_hi_q;
                        pop     = tx_hi_q;
                    end
                end else begin
                    // Low nibble is parked in stage until its high partner arrives.
                    if (mem_to_dma_valid && mem_to_dma_enable) begin
                        if (!rx_hi_q) begin
                            stage_d = mem_data_out;
                            rx_hi_d = 1'b1;
                        end else begin
                            push      = 1'b1;
                            push_data = {mem_data_out, stage_q};
                            rx_hi_d   = 1'b0;
                            in_cnt_d  = in_cnt_q + 32'd1;
                        end
                    end
                    if (dma_to_cpu_valid && dma_to_cpu_enable)
                        pop = 1'b1;
                end
                if (pop) begin
                    rd_ptr_d  = rd_ptr_q + (AW+1)'(1);
                    out_cnt_d = out_cnt_q + 32'd1;
                    if (out_cnt_q + 32'd1 == len_q)
                        state_d = S_IDLE;
                end
                if (push)
                    wr_ptr_d = wr_ptr_q + (AW+1)'(1);
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            addr_q    <= 32'd0;
            len_q     <= 32'd0;
            mode_q    <= 1'b0;
            in_cnt_q  <= 32'd0;
            out_cnt_q <= 32'd0;
            tx_hi_q   <= 1'b0;
            rx_hi_q   <= 1'b0;
            stage_q   <= 4'h0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            mode_q    <= mode_d;
            in_cnt_q  <= in_cnt_d;
            out_cnt_q <= out_cnt_d;
            tx_hi_q   <= tx_hi_d;
            rx_hi_q   <= rx_hi_d;
            stage_q   <= stage_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
        end
    end

    // NOTE: FIFO storage is not reset; resetting the pointers is enough to discard it.
    always_ff @(posedge clk) begin
        if (push)
            fifo_q[wr_ptr_q[AW-1:0]] <= push_data;
    end
endmodule

// File: tb/tb_dma_address.sv
// Directed bench for dma_address: reset, descriptor hold, both data directions,
// backpressure with randomized handshakes, zero-length and mid-transfer reset.
module tb_dma_address;
    logic        clk;
    logic        resetn;
    logic        mode;
    logic        address_in_valid;
    logic        address_in_enable;
    logic [31:0] addr_in;
    logic [31:0] len_in;
    logic        address_out_valid;
    logic        address_out_enable;
    logic [31:0] address_reg;
    logic [31:0] len_reg;
    logic        cpu_to_dma_valid;
    logic        cpu_to_dma_enable;
    logic [7:0]  cpu_data_out;
    logic        dma_to_cpu_valid;
    logic        dma_to_cpu_enable;
    logic [7:0]  cpu_data_in;
    logic        mem_to_dma_valid;
    logic        mem_to_dma_enable;
    logic [3:0]  mem_data_out;
    logic        dma_to_mem_valid;
    logic        dma_to_mem_enable;
    logic [3:0]  mem_data_in;

    int checks = 0;
    int errors = 0;

    dma_address #(.FIFO_DEPTH(4)) dut (
        .clk                (clk),
        .resetn             (resetn),
        .mode               (mode),
        .address_in_valid   (address_in_valid),
        .address_in_enable  (address_in_enable),
        .addr_in            (addr_in),
        .len_in             (len_in),
        .address_out_valid  (address_out_valid),
        .address_out_enable (address_out_enable),
        .address_reg        (address_reg),
        .len_reg            (len_reg),
        .cpu_to_dma_valid   (cpu_to_dma_valid),
        .cpu_to_dma_enable  (cpu_to_dma_enable),
        .cpu_data_out       (cpu_data_out),
        .dma_to_cpu_valid   (dma_to_cpu_valid),
        .dma_to_cpu_enable  (dma_to_cpu_enable),
        .cpu_data_in        (cpu_data_in),
        .mem_to_dma_valid   (mem_to_dma_valid),
        .mem_to_dma_enable  (mem_to_dma_enable),
        .mem_data_out       (mem_data_out),
        .dma_to_mem_valid   (dma_to_mem_valid),
        .dma_to_mem_enable  (dma_to_mem_enable),
        .mem_data_in        (mem_data_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents a descriptor for one cycle and lets memory accept it on the next edge.
    task automatic do_desc(input logic [31:0] a, input logic [31:0] l, input logic m);
        check("desc_in_enable", {31'd0, address_in_enable}, 32'd1);
        addr_in            = a;
        len_in             = l;
        mode               = m;
        address_in_valid   = 1'b1;
        address_out_enable = 1'b1;
        step();
        address_in_valid = 1'b0;
        check("desc_out_valid", {31'd0, address_out_valid}, 32'd1);
        step();
    endtask

    logic [7:0] bytes [16];
    logic [3:0] exp_nib [4];
    logic [3:0] lo_nib;
    logic       have_lo, hs_c, hs_m;
    logic [3:0] nib;
    int         sent, recv, seen_data;
    logic       idle_seen;

    initial begin
        resetn = 1'b0; mode = 1'b0; address_in_valid = 1'b0; addr_in = '0; len_in = '0;
        address_out_enable = 1'b0; cpu_to_dma_valid = 1'b0; cpu_data_out = '0;
        dma_to_cpu_enable = 1'b0; mem_to_dma_valid = 1'b0; mem_data_out = '0; dma_to_mem_enable = 1'b0;
        for (int i = 0; i < 16; i++) bytes[i] = 8'(i * 17 + 3);

        // Reset held for two cycles
        step();
        step();
        check("rst_hs_outputs", {26'd0, address_in_enable, address_out_valid, cpu_to_dma_enable,
              dma_to_cpu_valid, mem_to_dma_enable, dma_to_mem_valid}, 32'd0);
        resetn = 1'b1;
        #1;
        check("rel_addr_in_en", {31'd0, address_in_enable}, 32'd1);
        check("rel_address_reg", address_reg, 32'd0);
        check("rel_len_reg", len_reg, 32'd0);

        // Descriptor held until memory accepts it
        addr_in = 32'h1234_5678; len_in = 32'd12; mode = 1'b1; address_in_valid = 1'b1;
        step();
        address_in_valid = 1'b0;
        addr_in = 32'hDEAD_BEEF; len_in = 32'd99;
        for (int i = 0; i < 3; i++) begin
            check("desc_hold_valid", {31'd0, address_out_valid}, 32'd1);
            check("desc_hold_addr", address_reg, 32'h1234_5678);
            check("desc_hold_len", len_reg, 32'd12);
            step();
        end
        address_out_enable = 1'b1;
        step();
        address_out_enable = 1'b0;
        check("desc_left_addr", {31'd0, address_out_valid}, 32'd0);
        check("data_cpu_en", {31'd0, cpu_to_dma_enable}, 32'd1);

        // Backpressure: memory stalled, only four bytes fit
        sent = 0;
        cpu_to_dma_valid = 1'b1;
        dma_to_mem_enable = 1'b0;
        cpu_data_out = bytes[0];
        for (int i = 0; i < 8; i++) begin
            hs_c = cpu_to_dma_enable;
            step();
            if (hs_c) begin
                sent++;
                cpu_data_out = bytes[sent];
            end
        end
        check("bp_bytes_taken", 32'(sent), 32'd4);
        check("bp_full_enable", {31'd0, cpu_to_dma_enable}, 32'd0);
        check("bp_mem_valid", {31'd0, dma_to_mem_valid}, 32'd1);

        // Random valid/enable on both sides; all twelve bytes must arrive in order
        recv = 0; have_lo = 1'b0; lo_nib = '0;
        for (int cyc = 0; cyc < 2000 && recv < 12; cyc++) begin
            cpu_to_dma_valid  = 1'($urandom_range(0, 1));
            cpu_data_out      = bytes[sent & 15];
            dma_to_mem_enable = 1'($urandom_range(0, 1));
            hs_c = cpu_to_dma_valid & cpu_to_dma_enable;
            hs_m = dma_to_mem_valid & dma_to_mem_enable;
            nib  = mem_data_in;
            step();
            if (hs_c) sent++;
            if (hs_m) begin
                if (!have_lo) begin
                    lo_nib  = nib;
                    have_lo = 1'b1;
                end else begin
                    check("bp_byte", {24'd0, nib, lo_nib}, {24'd0, bytes[recv]});
                    recv++;
                    have_lo = 1'b0;
                end
            end
        end
        check("bp_recv_count", 32'(recv), 32'd12);
        check("bp_sent_count", 32'(sent), 32'd12);
        check("bp_idle_after", {31'd0, address_in_enable}, 32'd1);
        cpu_to_dma_valid = 1'b0; dma_to_mem_enable = 1'b0;

        // CPU to MEM, two bytes: nibbles 5,A,C,3
        exp_nib[0] = 4'h5; exp_nib[1] = 4'hA; exp_nib[2] = 4'hC; exp_nib[3] = 4'h3;
        do_desc(32'h0000_1000, 32'd2, 1'b1);
        address_out_enable = 1'b0;
        check("c2m_empty_start", {31'd0, dma_to_mem_valid}, 32'd0);
        sent = 0; recv = 0;
        dma_to_mem_enable = 1'b1;
        for (int cyc = 0; cyc < 20 && recv < 4; cyc++) begin
            cpu_to_dma_valid = (sent < 2);
            cpu_data_out     = (sent == 0) ? 8'hA5 : 8'h3C;
            hs_c = cpu_to_dma_valid & cpu_to_dma_enable;
            hs_m = dma_to_mem_valid & dma_to_mem_enable;
            nib  = mem_data_in;
            step();
            if (hs_c) sent++;
            if (hs_m) begin
                check("c2m_nibble", {28'd0, nib}, {28'd0, exp_nib[recv]});
                recv++;
            end
        end
        check("c2m_nib_count", 32'(recv), 32'd4);
        check("c2m_idle_after", {31'd0, address_in_enable}, 32'd1);
        cpu_to_dma_valid = 1'b0; dma_to_mem_enable = 1'b0;

        // MEM to CPU, one byte from nibbles 7 then E
        do_desc(32'h0000_2000, 32'd1, 1'b0);
        address_out_enable = 1'b0;
        check("m2c_mem_enable", {31'd0, mem_to_dma_enable}, 32'd1);
        mem_to_dma_valid = 1'b1; mem_data_out = 4'h7;
        step();
        check("m2c_half_valid", {31'd0, dma_to_cpu_valid}, 32'd0);
        mem_data_out = 4'hE;
        step();
        mem_to_dma_valid = 1'b0;
        check("m2c_cpu_valid", {31'd0, dma_to_cpu_valid}, 32'd1);
        check("m2c_cpu_data", {24'd0, cpu_data_in}, 32'h0000_00E7);
        check("m2c_src_limit", {31'd0, mem_to_dma_enable}, 32'd0);
        dma_to_cpu_enable = 1'b1;
        step();
        dma_to_cpu_enable = 1'b0;
        check("m2c_idle_after", {31'd0, address_in_enable}, 32'd1);
        check("m2c_valid_drop", {31'd0, dma_to_cpu_valid}, 32'd0);

        // Zero length: back to IDLE with no data traffic
        addr_in = 32'h0000_3000; len_in = 32'd0; mode = 1'b1;
        address_in_valid = 1'b1; address_out_enable = 1'b1;
        cpu_to_dma_valid = 1'b1; mem_to_dma_valid = 1'b1;
        step();
        address_in_valid = 1'b0;
        idle_seen = 1'b0; seen_data = 0;
        for (int cyc = 0; cyc < 4 && !idle_seen; cyc++) begin
            if (cpu_to_dma_enable | dma_to_mem_valid | mem_to_dma_enable | dma_to_cpu_valid) seen_data++;
            step();
            idle_seen = address_in_enable;
        end
        check("len0_idle", {31'd0, idle_seen}, 32'd1);
        check("len0_no_data", 32'(seen_data), 32'd0);
        cpu_to_dma_valid = 1'b0; mem_to_dma_valid = 1'b0;

        // Reset pulse mid-DATA discards the FIFO
        do_desc(32'h0000_4000, 32'd8, 1'b1);
        address_out_enable = 1'b0;
        cpu_to_dma_valid = 1'b1; dma_to_mem_enable = 1'b0; cpu_data_out = 8'h99;
        step();
        step();
        step();
        cpu_to_dma_valid = 1'b0;
        check("mid_fifo_busy", {31'd0, dma_to_mem_valid}, 32'd1);
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        #1;
        check("mid_rst_mem_valid", {31'd0, dma_to_mem_valid}, 32'd0);
        check("mid_rst_idle", {31'd0, address_in_enable}, 32'd1);
        check("mid_rst_addr", address_reg, 32'd0);
        do_desc(32'h0000_5000, 32'd1, 1'b1);
        address_out_enable = 1'b0;
        check("mid_fifo_empty", {31'd0, dma_to_mem_valid}, 32'd0);
        cpu_to_dma_valid = 1'b1; cpu_data_out = 8'h5A;
        step();
        cpu_to_dma_valid = 1'b0;
        check("post_rst_valid", {31'd0, dma_to_mem_valid}, 32'd1);
        check("post_rst_nib", {28'd0, mem_data_in}, 32'h0000_000A);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
